// File: rtl/bk_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bk_adder_pkg
// Description : Shared constants and elaboration-time helpers for the
//               pipelined Brent-Kung adder. It provides the log2, prefix-level
//               count and pipeline-latency functions that size the network and
//               the stage registers.
// Revision    : 1.0 - initial release
// ============================================================================
package bk_adder_pkg;

   localparam int unsigned C_MIN_WIDTH  = 8;
   localparam int unsigned C_MAX_WIDTH  = 64;
   localparam int unsigned C_MAX_LEVELS = 11;   // 2*log2(C_MAX_WIDTH)-1

   // Ceiling log2, usable in constant expressions.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((32'd1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   // Number of prefix levels in a Brent-Kung tree: up-sweep plus down-sweep.
   function automatic int unsigned bk_levels(input int unsigned width);
      return 2 * clog2(width) - 1;
   endfunction

   // Input register plus one register cut per group of reg_every levels.
   function automatic int unsigned bk_latency(input int unsigned levels,
                                              input int unsigned reg_every);
      return 1 + (levels + reg_every - 1) / reg_every;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bk_prefix_level.sv
`default_nettype none
// ============================================================================
// Module      : bk_prefix_level
// Description : One combinational row of a Brent-Kung prefix network.
//               Levels 1..log2(WIDTH) are up-sweep black cells combining
//               bit i with bit i-2^(LEVEL-1). Later levels are down-sweep gray
//               cells that fill the odd groups; P passes through unchanged.
// Ports       : g_in/p_in   - group generate/propagate entering this level
//               g_out/p_out - group generate/propagate leaving this level
// Revision    : 1.0 - initial release
// ============================================================================
module bk_prefix_level
   import bk_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned LEVEL = 1
) (
   input  logic [WIDTH-1:0] g_in,
   input  logic [WIDTH-1:0] p_in,
   output logic [WIDTH-1:0] g_out,
   output logic [WIDTH-1:0] p_out
);

   localparam int unsigned C_LOG2 = clog2(WIDTH);
   localparam bit          C_UP   = (LEVEL <= C_LOG2);
   // Up-sweep distance doubles each level; down-sweep distance halves from
   // WIDTH/4 down to 1.
   localparam int unsigned C_SPAN = C_UP ? (2 ** (LEVEL - 1))
                                         : (2 ** (2 * C_LOG2 - 1 - LEVEL));

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (C_UP && (((i + 1) % (2 * C_SPAN)) == 0)) begin : g_black
         assign g_out[i] = g_in[i] | (p_in[i] & g_in[i - C_SPAN]);
         assign p_out[i] = p_in[i] & p_in[i - C_SPAN];
      end else if (!C_UP && (((i + 1) % (2 * C_SPAN)) == C_SPAN)
                   && (i >= 2 * C_SPAN)) begin : g_gray
         assign g_out[i] = g_in[i] | (p_in[i] & g_in[i - C_SPAN]);
         assign p_out[i] = p_in[i];
      end else begin : g_pass
         assign g_out[i] = g_in[i];
         assign p_out[i] = p_in[i];
      end
   end

endmodule
`default_nettype wire

// File: rtl/bk_pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module      : bk_pipelined_adder
// Description : Pipelined Brent-Kung adder/subtractor with a valid/ready
//               handshake. It has an input register, then a register cut after
//               every REG_EVERY prefix levels. The last cut is the output
//               register holding the sum, carry, overflow and tag.
// Ports       : clk, rst               - clock, synchronous active-high reset
//               in_valid/in_ready      - input handshake
//               in_a, in_b             - operands
//               in_cin                 - carry-in (add) / borrow-in (sub)
//               in_sub                 - 0: A+B+cin, 1: A-B-cin
//               in_tag                 - user tag carried with the operation
//               out_valid/out_ready    - output handshake
//               out_sum                - WIDTH-bit result
//               out_cout               - carry-out (add) / NOT-borrow (sub)
//               out_ovf                - two's-complement overflow
//               out_tag                - tag of this result
// Revision    : 1.0 - initial release
// ============================================================================
module bk_pipelined_adder
   import bk_adder_pkg::*;
#(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned REG_EVERY = 3,
   parameter int unsigned TAG_W     = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic [TAG_W-1:0] out_tag
);

   localparam int unsigned C_NLEV = bk_levels(WIDTH);
   // Register stages in front of the output register. Stage s holds the
   // {G,P} that enters prefix level s*REG_EVERY+1.
   localparam int unsigned C_NSTG = bk_latency(C_NLEV, REG_EVERY) - 1;

   // ---------------------------------------------------------------------
   // Handshake: the pipeline moves as a whole, so bubbles are not collapsed.
   // ---------------------------------------------------------------------
   logic w_adv;
   assign w_adv    = !out_valid | out_ready;
   assign in_ready = w_adv;

   // ---------------------------------------------------------------------
   // Pre-processing: invert B and the carry for subtract, then fold the
   // carry-in into bit 0's generate so the prefix tree needs no extra column.
   // ---------------------------------------------------------------------
   logic [WIDTH-1:0] w_b;
   logic [WIDTH-1:0] w_p;
   logic [WIDTH-1:0] w_g_raw;
   logic [WIDTH-1:0] w_g;
   logic             w_c0;

   assign w_b     = in_sub ? ~in_b : in_b;
   assign w_c0    = in_sub ? ~in_cin : in_cin;
   assign w_p     = in_a ^ w_b;
   assign w_g_raw = in_a & w_b;
   assign w_g     = {w_g_raw[WIDTH-1:1], w_g_raw[0] | (w_p[0] & w_c0)};

   // ---------------------------------------------------------------------
   // Stage registers
   // ---------------------------------------------------------------------
   logic [WIDTH-1:0] r_g   [C_NSTG];
   logic [WIDTH-1:0] r_p   [C_NSTG];
   logic [WIDTH-1:0] r_po  [C_NSTG];   // original bitwise propagate for sum
   logic             r_c0  [C_NSTG];
   logic [TAG_W-1:0] r_tag [C_NSTG];
   logic             r_vld [C_NSTG];

   // ---------------------------------------------------------------------
   // Prefix network: a level takes its input from a stage register when it
   // starts a new stage, and from the previous level otherwise.
   // ---------------------------------------------------------------------
   logic [WIDTH-1:0] w_lg_in [1:C_NLEV];
   logic [WIDTH-1:0] w_lp_in [1:C_NLEV];
   logic [WIDTH-1:0] w_lg    [1:C_NLEV];
   logic [WIDTH-1:0] w_lp    [1:C_NLEV];

   for (genvar n = 1; n <= C_NLEV; n++) begin : g_level
      if (((n - 1) % REG_EVERY) == 0) begin : g_cut
         assign w_lg_in[n] = r_g[(n - 1) / REG_EVERY];
         assign w_lp_in[n] = r_p[(n - 1) / REG_EVERY];
      end else begin : g_chain
         assign w_lg_in[n] = w_lg[n - 1];
         assign w_lp_in[n] = w_lp[n - 1];
      end

      bk_prefix_level #(
         .WIDTH (WIDTH),
         .LEVEL (n)
      ) u_level (
         .g_in  (w_lg_in[n]),
         .p_in  (w_lp_in[n]),
         .g_out (w_lg[n]),
         .p_out (w_lp[n])
      );
   end

   // ---------------------------------------------------------------------
   // Post-processing: G[0:i] is the carry out of bit i (carry-in already
   // folded in), so the carry into bit i is G[0:i-1].
   // ---------------------------------------------------------------------
   logic [WIDTH-1:0] w_carry;
   logic [WIDTH-1:0] w_sum;
   logic             w_cout;
   logic             w_ovf;

   assign w_carry = {w_lg[C_NLEV][WIDTH-2:0], r_c0[C_NSTG-1]};
   assign w_sum   = r_po[C_NSTG-1] ^ w_carry;
   assign w_cout  = w_lg[C_NLEV][WIDTH-1];
   assign w_ovf   = w_carry[WIDTH-1] ^ w_cout;

   // ---------------------------------------------------------------------
   // Sequential: every stage, valid bit included, moves only on w_adv.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < C_NSTG; s++) begin
            r_vld[s] <= 1'b0;
            r_g[s]   <= '0;
            r_p[s]   <= '0;
            r_po[s]  <= '0;
            r_c0[s]  <= 1'b0;
            r_tag[s] <= '0;
         end
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_cout  <= 1'b0;
         out_ovf   <= 1'b0;
         out_tag   <= '0;
      end else if (w_adv) begin
         r_vld[0] <= in_valid;
         r_g[0]   <= w_g;
         r_p[0]   <= w_p;
         r_po[0]  <= w_p;
         r_c0[0]  <= w_c0;
         r_tag[0] <= in_tag;
         for (int s = 1; s < C_NSTG; s++) begin
            r_vld[s] <= r_vld[s-1];
            r_g[s]   <= w_lg[s * REG_EVERY];
            r_p[s]   <= w_lp[s * REG_EVERY];
            r_po[s]  <= r_po[s-1];
            r_c0[s]  <= r_c0[s-1];
            r_tag[s] <= r_tag[s-1];
         end
         out_valid <= r_vld[C_NSTG-1];
         out_sum   <= w_sum;
         out_cout  <= w_cout;
         out_ovf   <= w_ovf;
         out_tag   <= r_tag[C_NSTG-1];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bk_pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_bk_pipelined_adder
// Description : Directed self-checking bench for bk_pipelined_adder at
//               WIDTH=32, REG_EVERY=3 (latency 4). It covers reset, add and
//               subtract corner vectors, a stalled stream, a mid-flight reset
//               and a random valid/ready stream against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bk_pipelined_adder;

   localparam int W   = 32;
   localparam int RE  = 3;
   localparam int TW  = 4;
   localparam int LAT = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_a;
   logic [W-1:0]  in_b;
   logic          in_cin;
   logic          in_sub;
   logic [TW-1:0] in_tag;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_sum;
   logic          out_cout;
   logic          out_ovf;
   logic [TW-1:0] out_tag;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bk_pipelined_adder #(
      .WIDTH     (W),
      .REG_EVERY (RE),
      .TAG_W     (TW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .in_sub    (in_sub),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_ovf   (out_ovf),
      .out_tag   (out_tag)
   );

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      logic [W-1:0] s;
      logic         co;
      logic         ov;
   } vec_t;

   // Reference: {ovf, cout, sum}. Overflow uses the sign rule, not carries.
   function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin, input logic sub);
      logic [W-1:0] bb;
      logic         c;
      logic [W:0]   t;
      logic         ov;
      bb = sub ? ~b : b;
      c  = sub ? ~cin : cin;
      t  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c};
      ov = (a[W-1] == bb[W-1]) && (t[W-1] != a[W-1]);
      return {ov, t[W], t[W-1:0]};
   endfunction

   // Drive one operation into an idle pipeline and wait for its result.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input logic [TW-1:0] tag,
                        output logic [W-1:0] s, output logic co, output logic ov,
                        output logic [TW-1:0] tg, output int lat);
      @(negedge clk);
      in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_tag = tag;
      in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      in_cin = ~cin; in_sub = ~sub; in_tag = ~tag;   // must not be re-sampled
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      s = out_sum; co = out_cout; ov = out_ovf; tg = out_tag;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      in_a = 32'h1234_5678; in_b = 32'h1; in_cin = 1'b0; in_sub = 1'b0; in_tag = 4'h5;
      repeat (3) @(negedge clk);
      checks++;
      if ({out_valid, out_sum, out_cout, out_ovf, out_tag} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got v=%b s=%h c=%b o=%b t=%h, expected all zero",
                  out_valid, out_sum, out_cout, out_ovf, out_tag);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b expected 1", in_ready);
      end
      rst = 1'b0; in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ignored_input: got out_valid=%b expected 0 at cycle %0d", out_valid, i);
         end
      end
   endtask

   task automatic test_add();
      vec_t v[4];
      logic [W-1:0]  s;
      logic          co, ov;
      logic [TW-1:0] tg;
      int            lat;
      v[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
      v[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
      v[2] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0};
      v[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
      for (int i = 0; i < 4; i++) begin
         do_op(v[i].a, v[i].b, v[i].cin, v[i].sub, 4'(i + 1), s, co, ov, tg, lat);
         checks++;
         if ({s, co, ov} !== {v[i].s, v[i].co, v[i].ov}) begin
            errors++;
            $display("FAIL add_%0d: got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                     i, s, co, ov, v[i].s, v[i].co, v[i].ov);
         end
         checks++;
         if (lat != LAT || tg !== 4'(i + 1)) begin
            errors++;
            $display("FAIL add_%0d_lat_tag: got lat=%0d tag=%h expected lat=%0d tag=%h",
                     i, lat, tg, LAT, 4'(i + 1));
         end
      end
   endtask

   task automatic test_sub();
      vec_t v[5];
      logic [W-1:0]  s;
      logic          co, ov;
      logic [TW-1:0] tg;
      int            lat;
      v[0] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
      v[1] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
      v[2] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0006, 1'b1, 1'b0};
      v[3] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
      v[4] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1};
      for (int i = 0; i < 5; i++) begin
         do_op(v[i].a, v[i].b, v[i].cin, v[i].sub, 4'(i + 8), s, co, ov, tg, lat);
         checks++;
         if ({s, co, ov} !== {v[i].s, v[i].co, v[i].ov}) begin
            errors++;
            $display("FAIL sub_%0d: got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                     i, s, co, ov, v[i].s, v[i].co, v[i].ov);
         end
         checks++;
         if (lat != LAT || tg !== 4'(i + 8)) begin
            errors++;
            $display("FAIL sub_%0d_lat_tag: got lat=%0d tag=%h expected lat=%0d tag=%h",
                     i, lat, tg, LAT, 4'(i + 8));
         end
      end
   endtask

   // Eight back-to-back ops, downstream stalls for cycles 6..10.
   task automatic test_back_to_back_stall();
      int           sent = 0;
      int           got  = 0;
      int           cyc  = 0;
      int           extra = 0;
      logic [W+1:0] exp;
      while (got < 8 && cyc < 80) begin
         @(negedge clk);
         out_ready = !(cyc >= 6 && cyc < 11);
         in_valid  = (sent < 8);
         in_a      = 32'h0101_0101 * sent;
         in_b      = 32'hF0F0_F0F0 ^ sent;
         in_cin    = sent[0];
         in_sub    = sent[1];
         in_tag    = 4'(sent);
         #1;
         if (cyc >= 6 && cyc < 11) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
               errors++;
               $display("FAIL stall_hold: got in_ready=%b out_valid=%b expected 0/1 at cycle %0d",
                        in_ready, out_valid, cyc);
            end
         end
         if (out_valid && out_ready) begin
            exp = model(32'h0101_0101 * got, 32'hF0F0_F0F0 ^ got, got[0], got[1]);
            checks++;
            if ({out_tag, out_ovf, out_cout, out_sum} !== {4'(got), exp}) begin
               errors++;
               $display("FAIL stall_result_%0d: got tag=%h ovf=%b cout=%b sum=%h expected tag=%h ovf=%b cout=%b sum=%h",
                        got, out_tag, out_ovf, out_cout, out_sum, 4'(got), exp[W+1], exp[W], exp[W-1:0]);
            end
            got++;
         end
         if (in_valid && in_ready) sent++;
         cyc++;
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         if (out_valid) extra++;
         @(negedge clk);
      end
      checks++;
      if (got != 8 || sent != 8 || extra != 0) begin
         errors++;
         $display("FAIL stall_count: got received=%0d sent=%0d extra=%0d expected 8/8/0", got, sent, extra);
      end
   endtask

   task automatic test_reset_flush();
      int seen = 0;
      @(negedge clk);
      out_ready = 1'b1; in_sub = 1'b0; in_cin = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_a = 32'hAAAA_0000 + i; in_b = 32'h0000_1111; in_tag = 4'(i + 9);
         @(negedge clk);
      end
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL flush_filled: got out_valid=%b expected 1 before reset", out_valid);
      end
      rst = 1'b1;                 // in_valid stays high: must be ignored
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      checks++;
      if ({out_valid, out_sum, out_cout, out_ovf, out_tag} !== '0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_after_reset: got v=%b s=%h c=%b o=%b t=%h rdy=%b expected zeros and rdy=1",
                  out_valid, out_sum, out_cout, out_ovf, out_tag, in_ready);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL flush_stale: got %0d stale results expected 0", seen);
      end
   endtask

   task automatic test_random();
      logic [W+TW+1:0] q[$];
      logic [W+TW+1:0] exp;
      int              sent = 0;
      int              got  = 0;
      int              cyc  = 0;
      while (got < 300 && cyc < 5000) begin
         @(negedge clk);
         out_ready = ($urandom_range(3) != 0);
         in_valid  = (sent < 300) && ($urandom_range(2) != 0);
         in_a      = $urandom;
         in_b      = ($urandom_range(3) == 0) ? ~in_a : $urandom;
         in_cin    = 1'($urandom_range(1));
         in_sub    = 1'($urandom_range(1));
         in_tag    = 4'($urandom_range(15));
         #1;
         if (out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL rand_spurious: got result sum=%h tag=%h expected none", out_sum, out_tag);
            end else begin
               exp = q.pop_front();
               if ({out_tag, out_ovf, out_cout, out_sum} !== exp) begin
                  errors++;
                  $display("FAIL rand_%0d: got %h expected %h", got, {out_tag, out_ovf, out_cout, out_sum}, exp);
               end
            end
            got++;
         end
         if (in_valid && in_ready) begin
            q.push_back({in_tag, model(in_a, in_b, in_cin, in_sub)});
            sent++;
         end
         cyc++;
      end
      checks++;
      if (got != 300 || q.size() != 0) begin
         errors++;
         $display("FAIL rand_count: got received=%0d pending=%0d expected 300/0", got, q.size());
      end
      in_valid = 1'b0; out_ready = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0; in_tag = '0;
      test_reset();
      test_add();
      test_sub();
      test_back_to_back_stall();
      test_reset_flush();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
